vga_controller: RTL and testbench

VGA_CONTROLLER -- requirements
Module: vga_controller

---
 rtl/vga_controller.sv | 100 ++++++++++
 tb/tb_vga_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vga_controller.sv
// VGA timing generator: pixel strobe at half the system clock, line/frame counters
// with origin at the start of sync, and registered sync/visible-window decode.
module vga_controller #(
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       display_pixel,
    output logic       pix_en,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;

    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
    localparam logic [9:0] H_VIS_START = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_VIS_END   = 10'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [9:0] V_VIS_START = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_VIS_END   = 10'(V_SYNC + V_BACK + V_VISIBLE);

    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    logic       pix_en_q, pix_en_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       display_q, display_d;
    logic       frame_start_q, frame_start_d;

    always_comb begin
        pix_en_d = ~pix_en_q;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en_q) begin
            if (hcount_q >= H_LAST) begin
                hcount_d = '0;
                if (vcount_q >= V_LAST) begin
                    vcount_d = '0;
                end else begin
                    vcount_d = vcount_q + 10'd1;
                end
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end
    end

    // Decode is taken from the next counter values so the registered outputs
    // line up with hcount/vcount on the same edge.
    always_comb begin
        hsync_d       = (hcount_d >= H_SYNC_END);
        vsync_d       = (vcount_d >= V_SYNC_END);
        display_d     = (hcount_d >= H_VIS_START) && (hcount_d < H_VIS_END) &&
                        (vcount_d >= V_VIS_START) && (vcount_d < V_VIS_END);
        frame_start_d = pix_en_d && (hcount_d == '0) && (vcount_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            pix_en_q      <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            display_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            pix_en_q      <= pix_en_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_q     <= display_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcount        = hcount_q;
    assign vcount        = vcount_q;
    assign pix_en        = pix_en_q;
    assign hsync         = hsync_q;
    assign vsync         = vsync_q;
    assign display_pixel = display_q;
    assign frame_start   = frame_start_q;

endmodule

// File: tb/tb_vga_controller.sv
// Directed bench for vga_controller: default timing for reset/line behaviour,
// a reduced timing instance for whole-frame, corner-wrap and mid-frame reset.
module tb_vga_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] d_hcount, d_vcount;
    logic       d_hsync, d_vsync, d_disp, d_pix, d_fs;
    logic [9:0] s_hcount, s_vcount;
    logic       s_hsync, s_vsync, s_disp, s_pix, s_fs;

    vga_controller dut_d (
        .clk(clk), .rst_n(rst_n), .hcount(d_hcount), .vcount(d_vcount),
        .hsync(d_hsync), .vsync(d_vsync), .display_pixel(d_disp),
        .pix_en(d_pix), .frame_start(d_fs)
    );

    // Small frame: H total 17 (sync 0..3, visible 7..14), V total 9 (sync 0..1, visible 4..7)
    vga_controller #(
        .H_SYNC(4), .H_BACK(3), .H_VISIBLE(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_VISIBLE(4), .V_FRONT(1)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .hcount(s_hcount), .vcount(s_vcount),
        .hsync(s_hsync), .vsync(s_vsync), .display_pixel(s_disp),
        .pix_en(s_pix), .frame_start(s_fs)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic rst_n;
        logic pix;
        int   h;
        int   v;
        logic hs;
        logic vs;
        logic dp;
        logic fs;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int low, high, first_high, hmis, vmis, pmis, fs_cnt, dp_cnt;
        int vs_low, dp_high, fs_first, fs_second, waited;

        vecs[0] = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset and release on the default-timing instance
        for (int i = 0; i < 7; i++) begin
            rst_n = vecs[i].rst_n;
            step();
            chk($sformatf("vec%0d_pix", i), d_pix, vecs[i].pix);
            chk($sformatf("vec%0d_hcount", i), d_hcount, vecs[i].h);
            chk($sformatf("vec%0d_vcount", i), d_vcount, vecs[i].v);
            chk($sformatf("vec%0d_hsync", i), d_hsync, vecs[i].hs);
            chk($sformatf("vec%0d_vsync", i), d_vsync, vecs[i].vs);
            chk($sformatf("vec%0d_disp", i), d_disp, vecs[i].dp);
            chk($sformatf("vec%0d_fs", i), d_fs, vecs[i].fs);
        end

        // One full default line from a fresh reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        low = 0; high = 0; first_high = -1; hmis = 0; vmis = 0; pmis = 0;
        fs_cnt = 0; dp_cnt = 0;
        for (int n = 0; n <= 1600; n++) begin
            if (n > 0) step();
            if (n < 1600) begin
                if (!d_hsync) low++;
                else begin
                    high++;
                    if (first_high < 0) first_high = n;
                end
                if (int'(d_hcount) != n / 2) hmis++;
                if (d_vcount != 10'd0) vmis++;
                if (int'(d_pix) != n % 2) pmis++;
                fs_cnt += int'(d_fs);
                dp_cnt += int'(d_disp);
            end
        end
        chk("line_hsync_low_clks", low, 192);
        chk("line_hsync_high_clks", high, 1408);
        chk("line_hsync_first_high", first_high, 192);
        chk("line_hcount_seq_errors", hmis, 0);
        chk("line_vcount_errors", vmis, 0);
        chk("line_pix_en_errors", pmis, 0);
        chk("line_frame_start_count", fs_cnt, 1);
        chk("line_display_count", dp_cnt, 0);
        chk("line_wrap_hcount", d_hcount, 0);
        chk("line_wrap_vcount", d_vcount, 1);

        // Whole small frame plus the corner wrap into the next one
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        vs_low = 0; dp_high = 0; fs_first = -1; fs_second = -1;
        for (int n = 0; n <= 308; n++) begin
            int p, eh, ev, epix;
            if (n > 0) step();
            p = n / 2;
            eh = p % 17;
            ev = (p / 17) % 9;
            epix = n % 2;
            chk($sformatf("frm_h@%0d", n), s_hcount, eh);
            chk($sformatf("frm_v@%0d", n), s_vcount, ev);
            chk($sformatf("frm_pix@%0d", n), s_pix, epix);
            chk($sformatf("frm_hs@%0d", n), s_hsync, int'(eh >= 4));
            chk($sformatf("frm_vs@%0d", n), s_vsync, int'(ev >= 2));
            chk($sformatf("frm_dp@%0d", n), s_disp,
                int'(eh >= 7 && eh < 15 && ev >= 4 && ev < 8));
            chk($sformatf("frm_fs@%0d", n), s_fs,
                int'(eh == 0 && ev == 0 && epix == 1));
            if (n < 306) begin
                if (!s_vsync) vs_low++;
                dp_high += int'(s_disp);
            end
            if (s_fs) begin
                if (fs_first < 0) fs_first = n;
                else if (fs_second < 0) fs_second = n;
            end
        end
        chk("frame_vsync_low_clks", vs_low, 68);
        chk("frame_display_clks", dp_high, 64);
        chk("frame_start_first", fs_first, 1);
        chk("frame_start_period", fs_second - fs_first, 306);

        // Reset for one clk in the middle of the visible window
        waited = 0;
        while (!(s_hcount == 10'd10 && s_vcount == 10'd5) && waited < 400) begin
            step();
            waited++;
        end
        chk("reach_10_5_in_budget", int'(waited < 400), 1);
        chk("pre_reset_display", s_disp, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_hcount", s_hcount, 0);
        chk("mid_rst_vcount", s_vcount, 0);
        chk("mid_rst_pix", s_pix, 0);
        chk("mid_rst_disp", s_disp, 0);
        chk("mid_rst_hsync", s_hsync, 0);
        chk("mid_rst_vsync", s_vsync, 0);
        chk("mid_rst_fs", s_fs, 0);
        chk("mid_rst_d_hcount", d_hcount, 0);
        chk("mid_rst_d_pix", d_pix, 0);
        for (int n = 1; n <= 4; n++) begin
            step();
            chk($sformatf("resume_pix@%0d", n), s_pix, n % 2);
            chk($sformatf("resume_h@%0d", n), s_hcount, n / 2);
            chk($sformatf("resume_v@%0d", n), s_vcount, 0);
            chk($sformatf("resume_fs@%0d", n), s_fs, int'(n == 1));
            chk($sformatf("resume_d_h@%0d", n), d_hcount, n / 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
